// File: rtl/display.sv
// rtl/display.sv - two-digit time-multiplexed seven-segment digit driver
module display #(
    parameter int BASE     = 16,
    parameter int PRESCALE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] num,
    output logic [3:0] bcd,
    output logic       cat
);

    localparam int CW = $clog2(PRESCALE) + 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    // Reject radices and prescales the digit logic cannot represent.
    if (BASE != 10 && BASE != 16) begin : g_bad_base
        $error("display: BASE must be 10 or 16");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("display: PRESCALE must be at least 1");
    end

    logic [CW-1:0] cnt;
    logic [3:0]    lo;
    logic [3:0]    hi;
    logic          cat_next;
    logic          wrap;

    if (BASE == 16) begin : g_hex
        // Hex digits are just the two nibbles.
        always_comb begin
            lo = num[3:0];
            hi = num[7:4];
        end
    end else begin : g_dec
        logic [7:0] q10;
        logic [7:0] r_lo;
        logic [7:0] r_hi;
        // Decimal digits by constant divide; hundreds are dropped.
        always_comb begin
            q10  = num / 8'd10;
            r_lo = num % 8'd10;
            r_hi = q10 % 8'd10;
            lo   = r_lo[3:0];
            hi   = r_hi[3:0];
        end
    end

    // Select flips when the prescale window ends on this edge.
    always_comb begin
        wrap     = (cnt == LAST);
        cat_next = wrap ? ~cat : cat;
    end

    // Prescale counter, digit select and the digit value presented with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            cat <= 1'b0;
            bcd <= 4'h0;
        end else begin
            cnt <= wrap ? '0 : cnt + 1'b1;
            cat <= cat_next;
            bcd <= cat_next ? hi : lo;
        end
    end

endmodule

// File: tb/tb_display.sv
// tb/tb_display.sv - randomized self-checking bench for display
module tb_display;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] num = 8'h00;

    logic [3:0] bcd16, bcd10, bcd4;
    logic       cat16, cat10, cat4;

    int total = 0;
    int bad   = 0;
    int n     = 0;
    int last_num = 0;

    always #5 clk = ~clk;

    display #(.BASE(16), .PRESCALE(1)) u16 (.clk(clk), .rst(rst), .num(num), .bcd(bcd16), .cat(cat16));
    display #(.BASE(10), .PRESCALE(1)) u10 (.clk(clk), .rst(rst), .num(num), .bcd(bcd10), .cat(cat10));
    display #(.BASE(16), .PRESCALE(4)) u4  (.clk(clk), .rst(rst), .num(num), .bcd(bcd4),  .cat(cat4));

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t num=%0d)", tag, got, exp, $time, last_num);
        end
    endtask

    function automatic int digit(input int v, input int base, input int sel_hi);
        if (base == 16) return sel_hi != 0 ? (v / 16) % 16 : v % 16;
        return sel_hi != 0 ? (v / 10) % 10 : v % 10;
    endfunction

    // After n edges out of reset, the select has flipped once per completed window.
    task automatic check_all(input string tag);
        int c1, c4;
        if (rst) begin
            check({tag, " cat16"}, cat16, 0); check({tag, " bcd16"}, bcd16, 0);
            check({tag, " cat10"}, cat10, 0); check({tag, " bcd10"}, bcd10, 0);
            check({tag, " cat4"},  cat4,  0); check({tag, " bcd4"},  bcd4,  0);
        end else begin
            c1 = n % 2;
            c4 = (n / 4) % 2;
            check({tag, " cat16"}, cat16, c1); check({tag, " bcd16"}, bcd16, digit(last_num, 16, c1));
            check({tag, " cat10"}, cat10, c1); check({tag, " bcd10"}, bcd10, digit(last_num, 10, c1));
            check({tag, " cat4"},  cat4,  c4); check({tag, " bcd4"},  bcd4,  digit(last_num, 16, c4));
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        last_num = num;
        if (!rst) n++;
        #1;
        check_all(tag);
    endtask

    task automatic hold(input int v, input int edges, input string tag);
        num = 8'(v);
        for (int i = 0; i < edges; i++) tick(tag);
    endtask

    initial begin
        int diag [15] = '{8'h1E, 8'h2D, 8'h3C, 8'h4B, 8'h5A, 8'h69, 8'h78, 8'h87,
                          8'h96, 8'hA5, 8'hB4, 8'hC3, 8'hD2, 8'hE1, 8'hF0};
        int dec [3] = '{57, 255, 9};

        // Reset is visible before any clock edge.
        #2;
        check_all("reset_noclk");
        tick("reset_held");
        @(negedge clk);
        rst = 1'b0;
        n   = 0;
        tick("first_edge");
        check("first_edge cat", cat16, 1);

        for (int v = 0; v < 16; v++) hold(v, 2, "sweep");
        foreach (diag[i]) hold(diag[i], 2, "diag");
        foreach (dec[i]) hold(dec[i], 2, "dec");
        for (int v = 0; v < 256; v++) hold(v, 2, "exhaustive");

        // Prescale window: value held steady across several windows.
        hold(8'h3C, 12, "prescale");

        for (int i = 0; i < 150; i++) hold(int'($urandom_range(0, 255)), int'($urandom_range(1, 5)), "random");

        // Mid-run asynchronous reset while the high digit is showing.
        if (n % 2 == 0) hold(8'hA5, 1, "pre_reset");
        else hold(8'hA5, 2, "pre_reset");
        check("pre_reset cat", cat16, 1);
        rst = 1'b1;
        #1;
        check_all("async_reset");
        tick("reset_midrun");
        @(negedge clk);
        rst = 1'b0;
        n   = 0;
        for (int i = 0; i < 100; i++) hold(int'($urandom_range(0, 255)), int'($urandom_range(1, 6)), "post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
